// File: rtl/oven_timer_ctrl.sv
// rtl/oven_timer_ctrl.sv - oven timer sequencer: panel events to BCD counter-chain strobes
// Divides clk into the one-second decrement tick and drives magnetron/done indications.
module oven_timer_ctrl #(
  parameter int CLK_DIV     = 50_000_000,
  parameter int DONE_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_btn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic       zero,
  output logic       cnt_enable,
  output logic       cnt_load_n,
  output logic       cnt_clear_n,
  output logic       magnetron_on,
  output logic       done,
  output logic [2:0] state
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int DW = $clog2(DONE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DONE_MAX  = DW'(DONE_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SET   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] done_cnt_q, done_cnt_d;
  logic          start_q, stop_q, clear_q;
  logic          load_n_q, clear_n_q;
  logic          load_req, clear_req;
  logic          start_edge, stop_edge, clear_edge;

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop & ~stop_q;
  assign clear_edge = clear_btn & ~clear_q;

  // cnt_clear_n resets low so the counter chain always sees a clear after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      done_cnt_q <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      clear_q    <= 1'b0;
      load_n_q   <= 1'b1;
      clear_n_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      done_cnt_q <= done_cnt_d;
      start_q    <= start;
      stop_q     <= stop;
      clear_q    <= clear_btn;
      load_n_q   <= ~load_req;
      clear_n_q  <= ~clear_req;
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    done_cnt_d = done_cnt_q;
    load_req   = 1'b0;
    clear_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          load_req = 1'b1;
          state_d  = S_SET;
        end
      end
      S_SET: begin
        if (clear_edge) begin
          clear_req = 1'b1;
          state_d   = S_IDLE;
        end else if (key_valid) begin
          load_req = 1'b1;
        end else if (start_edge && door_closed && !zero) begin
          state_d = S_RUN;
          presc_d = '0;
        end
      end
      S_RUN: begin
        if (clear_edge) begin
          clear_req = 1'b1;
          state_d   = S_IDLE;
        end else if (zero) begin
          state_d    = S_DONE;
          done_cnt_d = '0;
        end else if (stop_edge || !door_closed) begin
          state_d = S_PAUSE;
        end else begin
          presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (clear_edge || stop_edge) begin
          clear_req = 1'b1;
          state_d   = S_IDLE;
        end else if (start_edge && door_closed) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (start_edge || stop_edge || clear_edge || done_cnt_q == DONE_MAX) begin
          clear_req = 1'b1;
          state_d   = S_IDLE;
        end else begin
          done_cnt_d = done_cnt_q + 1'b1;
        end
      end
      default: begin
        clear_req = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Tick gating uses live inputs so a pause or expiry cycle never decrements.
  always_comb begin
    cnt_enable   = (state_q == S_RUN) && (presc_q == PRESC_MAX) && !zero &&
                   door_closed && !stop_edge && !clear_edge;
    magnetron_on = (state_q == S_RUN) && door_closed;
    done         = (state_q == S_DONE);
  end

  assign cnt_load_n  = load_n_q;
  assign cnt_clear_n = clear_n_q;
  assign state       = state_q;

endmodule

// File: doc/oven_timer_ctrl.md
# oven_timer_ctrl

Sequencing controller for the cooking timer's cascade of BCD down-counters (seconds-units mod-10, seconds-tens mod-6, minutes mod-10). It converts button, door and keypad events into the counters' load, enable and clear strobes. It divides the system clock into a one-second decrement tick and drives the magnetron and done indications. The block sits between the synchronized front-panel inputs and the counter chain. It holds no time value itself: it observes the chain's all-zero flag.

## Interface
- CLK_DIV, default 50_000_000: clock cycles per decrement tick; legal values are ≥ 2.
- DONE_CYCLES, default 100_000_000: cycles the `done` output is held after expiry; legal values are ≥ 1.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  start button level, already synchronized.
- stop  in  1  stop/cancel button level, already synchronized.
- clear_btn  in  1  clear button level, already synchronized.
- door_closed  in  1  1 = door shut.
- key_valid  in  1  single-cycle strobe: keypad digit ready on counter data bus.
- zero  in  1  AND of all counters' count_end; 1 = time is 00:00.
- cnt_enable  out  1  counter chain decrement enable.
- cnt_load_n  out  1  active-low parallel load to the counter chain.
- cnt_clear_n  out  1  active-low clear; the counters clear on its falling edge.
- magnetron_on  out  1  heating on.
- done  out  1  cooking finished indication.
- state  out  3  current state encoding, for debug and display.

## Operation
- Edge detection:
  - start, stop and clear_btn are registered internally.
  - Only rising edges act; a held level is ignored after its first cycle.
  - Edge registers reset to 0, so a button held through reset fires one edge in the first cycle after release.
- States: IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4. Codes 5–7 go to IDLE and request a clear.
- IDLE:
  - key_valid → load pulse, go to SET.
  - Other inputs ignored.
- SET. Priority order:
  - clear_btn edge → clear pulse, go to IDLE.
  - key_valid → load pulse, stay in SET.
  - start edge with door_closed=1 and zero=0 → go to RUN; prescaler := 0.
  - start with door open or zero=1 → ignored.
- RUN. Priority order:
  - clear_btn edge → clear pulse, go to IDLE.
  - zero=1 → go to DONE; done counter := 0.
  - stop edge or door_closed=0 → go to PAUSE; prescaler holds its value.
  - Otherwise prescaler increments and wraps CLK_DIV-1 → 0.
- PAUSE:
  - clear_btn edge or stop edge → clear pulse, go to IDLE.
  - start edge with door_closed=1 → go to RUN; prescaler resumes from its held value.
  - key_valid → ignored.
- DONE:
  - done counter increments each cycle.
  - When it reaches DONE_CYCLES-1 → clear pulse, go to IDLE.
  - Any start, stop or clear_btn edge → clear pulse, go to IDLE immediately.
- Decrement enable:
  - cnt_enable = (state==RUN) & (prescaler==CLK_DIV-1) & ~zero & door_closed & ~stop edge & ~clear_btn edge.
  - This is combinational from registers plus inputs, so the counters never decrement past 00:00 and never tick on a pause cycle.
- magnetron_on = (state==RUN) & door_closed, decoded combinationally. It is 0 in the cycle the door opens.
- done = (state==DONE).
- Widths:
  - The prescaler is $clog2(CLK_DIV) bits.
  - The done counter is $clog2(DONE_CYCLES+1) bits.
  - Neither counter exceeds its terminal value.

## Timing
- Reset values (asynchronous, effective immediately):
  - state=IDLE, prescaler=0, done counter=0, edge registers=0.
  - cnt_load_n=1, cnt_enable=0, magnetron_on=0, done=0.
  - cnt_clear_n=0 during reset. It rises to 1 on the first clk edge after reset deasserts, so the counters always see a clear.
- Load pulse: cnt_load_n is registered and goes low for exactly 1 cycle, the cycle after the key_valid cycle.
- Clear pulse: cnt_clear_n is registered and goes low for exactly 1 cycle, the cycle after the triggering event. Back-to-back events produce back-to-back pulses; 1 is never held low for more than 1 cycle except during reset.
- Start → RUN: 1 cycle. The first cnt_enable comes CLK_DIV cycles after the start edge cycle.
- Tick period in RUN: exactly CLK_DIV cycles.
- Expiry:
  - The counters reach 0 on the edge ending the tick cycle; zero is visible the next cycle.
  - The FSM enters DONE one edge later. No further tick occurs because CLK_DIV ≥ 2.
- done is high for exactly DONE_CYCLES cycles, unless cancelled early.
- Reset mid-RUN: all outputs drop to their reset values asynchronously; the prescaler's partial count is discarded.

## Test plan
- Reset then release (CLK_DIV=4, DONE_CYCLES=3) → cnt_clear_n low during reset, 1 from the first edge; state=0; all other outputs at reset values.
- key_valid at cycle 10 → cnt_load_n low only in cycle 11; state=SET. start edge with zero=0 → RUN at the next cycle; cnt_enable high every 4th cycle; magnetron_on=1.
- Counter model loaded to 00:02 → exactly 2 cnt_enable pulses. After zero rises, DONE follows in 1 cycle; done is high for 3 cycles; cnt_clear_n pulses once; back to IDLE.
- Door opens when prescaler=2 → PAUSE; magnetron_on=0 in the same cycle; no cnt_enable. Door closes plus start edge → first cnt_enable after 1 more prescaler step (value 3).
- stop held high across 5 cycles in RUN → single PAUSE entry. Second stop edge → clear pulse, IDLE.
- start edge in SET with zero=1 or door open → stays in SET. Reset asserted mid-RUN → immediate IDLE, cnt_enable=0, cnt_clear_n=0.
